regfile_arb: RTL and testbench
==============================

# regfile_arb

Arbiter and access sequencer for the shared 128×8 register file. It sits between the SPI host port and the motor-controller scan engine. It serialises both requesters onto a single external synchronous RAM port, returns read data to the requester that issued the read, and guarantees the scan engine bounded latency under heavy SPI traffic. An optional lock keeps multi-byte position updates atomic with respect to the host.

## Interface
Parameters:
- `ADDR_W`, 7: register address width.
- `DATA_W`, 8: register data width.
- `STARVE_LIMIT`, 4: maximum number of consecutive host grants while `mc_req` is pending; range 1..15.
- `LOCK_MAX`, 8: maximum number of cycles the lock may be held; range 1..255.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `host_req`, `host_we`, in, 1 each: host access request and write enable.
- `host_addr`, in, `ADDR_W`; `host_wdata`, in, `DATA_W`: host address and write data.
- `host_gnt`, out, 1: host access accepted this cycle (combinational).
- `host_rvalid`, out, 1; `host_rdata`, out, `DATA_W`: host read return.
- `mc_req`, `mc_we`, `mc_lock`, in, 1 each: scan-engine request, write enable and lock request.
- `mc_addr`, in, `ADDR_W`; `mc_wdata`, in, `DATA_W`: scan-engine address and write data.
- `mc_gnt`, out, 1: scan-engine access accepted this cycle (combinational).
- `mc_rvalid`, out, 1; `mc_rdata`, out, `DATA_W`: scan-engine read return.
- `mem_en`, `mem_we`, out, 1 each: RAM port enable and write enable (registered).
- `mem_addr`, out, `ADDR_W`; `mem_wdata`, out, `DATA_W`: RAM port address and write data (registered).
- `mem_rdata`, in, `DATA_W`: RAM read data, valid one cycle after `mem_en`.
- `lock_err`, out, 1: one-cycle pulse when the lock is force-released.

## Operation
- An access transfers in any cycle where `req && gnt`. At most one grant is issued per cycle. A requester holds its request fields stable until granted.
- State machine, state `ARB`:
  - Both requesting: host wins while `starve_cnt < STARVE_LIMIT`.
  - At `starve_cnt == STARVE_LIMIT`: the scan engine wins.
  - Only one requesting: that requester wins.
- `starve_cnt` (4 bit):
  - Increments on each host grant while `mc_req` is high.
  - Clears on any scan-engine grant, and in any cycle where `mc_req` is low.
- State `LOCKED`:
  - Entry: from `ARB` on a scan-engine grant with `mc_lock` = 1.
  - Only the scan engine is granted; `host_gnt` = 0.
  - Exit to `ARB`: on any cycle with `mc_lock` = 0, or on a scan-engine grant with `mc_lock` = 0.
  - `lock_cnt` counts cycles spent in `LOCKED`. On reaching `LOCK_MAX`, the block forces `ARB`, pulses `lock_err` and clears `starve_cnt`. After a forced exit, the host has priority for the next contested cycle regardless of `starve_cnt`.
- Read return: a 2-stage owner pipeline tags each issued read as host or scan engine. `mem_rdata` is routed to that owner's `rdata`, with `rvalid` high for exactly one cycle. The other requester's `rdata` holds its previous value.
- Writes produce no return.
- Reset mid-operation: in-flight reads are discarded and no `rvalid` is asserted for them.

## Timing
- Reset values:
  - Outputs: `host_gnt`, `mc_gnt`, both `rvalid` = 0; both `rdata` = 0; all `mem_*` = 0; `lock_err` = 0.
  - State: `ARB`; `starve_cnt` and `lock_cnt` = 0.
- Grant at edge T, then `mem_*` driven in cycle T+1, then `rvalid`/`rdata` in cycle T+2.
- Throughput: one access per cycle, no bubbles between back-to-back grants.
- `mem_en` = 0 in every cycle following a cycle with no grant.
- Worst-case scan-engine wait in `ARB`: `STARVE_LIMIT`+1 cycles.
- Worst-case host wait: `LOCK_MAX`+1 cycles.

## Configuration
- `REGFILE_ARB_LOCK_EN` defined: the `LOCKED` state, `lock_cnt` and `lock_err` are implemented as described above.
- Undefined: `mc_lock` is ignored, the state machine is `ARB` only, and `lock_err` is tied to 0.

## Test plan
- Host-only read of addr 0x05 holding 0xA7 at T: expect `host_gnt`=1 at T, `mem_en`/`mem_addr`=0x05 at T+1, `host_rvalid`=1 with `host_rdata`=0xA7 at T+2, `mc_rvalid`=0 throughout.
- Both requesting continuously, `STARVE_LIMIT`=4: expect grant sequence H,H,H,H,M repeating; `starve_cnt` never exceeds 4.
- Scan engine locks for writes to 0x41..0x43 while host requests: expect the host is granted only after the cycle in which `mc_lock` falls; RAM write order 0x41, 0x42, 0x43 with no host access interleaved.
- `mc_lock` held high for 20 cycles, `LOCK_MAX`=8: expect `lock_err` pulse in cycle 8 of `LOCKED` and a host grant on the next contested cycle.
- Interleaved reads M(0x10)=0x11, H(0x20)=0x22 in consecutive cycles: expect `mc_rvalid` with 0x11, then `host_rvalid` with 0x22 one cycle later.
- Assert `reset` low with two reads in flight: expect all outputs at reset values immediately, and no `rvalid` after `reset` is released.

Source files
------------

// File: rtl/regfile_arb_if.sv
// Port bundle for regfile_arb: host and scan-engine request/return channels plus the RAM port.
// slave is the arbiter's view; master is the requesters' and RAM's view.
interface regfile_arb_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mc_req;
  logic              mc_we;
  logic              mc_lock;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_wdata;
  logic              mc_gnt;
  logic              mc_rvalid;
  logic [DATA_W-1:0] mc_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              lock_err;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    input  mc_req, mc_we, mc_lock, mc_addr, mc_wdata,
    output mc_gnt, mc_rvalid, mc_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output lock_err
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    output mc_req, mc_we, mc_lock, mc_addr, mc_wdata,
    input  mc_gnt, mc_rvalid, mc_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  lock_err
  );
endinterface

// File: rtl/regfile_arb.sv
// regfile_arb: serialises host and scan-engine accesses onto one synchronous RAM port.
// Define REGFILE_ARB_LOCK_EN to build the scan-engine lock (LOCKED state, lock_cnt, lock_err).
module regfile_arb #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input logic          clk,
  input logic          reset,
  regfile_arb_if.slave bus
);
  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
`ifdef REGFILE_ARB_LOCK_EN
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic              host_prio_q, host_prio_d;
`endif
  logic              host_first, arb_host, arb_mc;
  logic              host_gnt, mc_gnt, lock_err;

  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_v1_q, rd_v1_d, rd_mc1_q, rd_mc1_d;
  logic              rd_v2_q, rd_v2_d, rd_mc2_q, rd_mc2_d;
  logic              host_rvalid, mc_rvalid;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d, mc_rdata_q, mc_rdata_d;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    arb_host   = 1'b0;
    arb_mc     = 1'b0;
    lock_err   = 1'b0;
    host_first = (starve_q < 4'(STARVE_LIMIT));
`ifdef REGFILE_ARB_LOCK_EN
    lock_cnt_d  = lock_cnt_q;
    host_prio_d = host_prio_q;
    host_first  = host_first | host_prio_q;
`endif
    case (state_q)
      ARB: begin
        if (bus.host_req && bus.mc_req) begin
          arb_host = host_first;
          arb_mc   = !host_first;
`ifdef REGFILE_ARB_LOCK_EN
          host_prio_d = 1'b0;
`endif
        end else begin
          arb_host = bus.host_req;
          arb_mc   = bus.mc_req;
        end
`ifdef REGFILE_ARB_LOCK_EN
        if (arb_mc && bus.mc_lock) begin
          state_d    = LOCKED;
          lock_cnt_d = '0;
        end
`endif
      end
`ifdef REGFILE_ARB_LOCK_EN
      LOCKED: begin
        arb_mc     = bus.mc_req;
        lock_cnt_d = lock_cnt_q + 8'd1;
        if (!bus.mc_lock) begin
          state_d = ARB;
        end else if (lock_cnt_d == 8'(LOCK_MAX)) begin
          // Forced release: the host takes the next contested cycle.
          state_d     = ARB;
          lock_err    = 1'b1;
          host_prio_d = 1'b1;
        end
      end
`endif
      default: state_d = ARB;
    endcase

    // Grants are combinational, so they are masked while reset is held.
    host_gnt = arb_host & reset;
    mc_gnt   = arb_mc & reset;

    if (!bus.mc_req || mc_gnt || lock_err) starve_d = '0;
    else if (host_gnt)                     starve_d = starve_q + 4'd1;
  end

  always_comb begin
    mem_en_d    = host_gnt | mc_gnt;
    mem_we_d    = (host_gnt & bus.host_we) | (mc_gnt & bus.mc_we);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (host_gnt) begin
      mem_addr_d  = bus.host_addr;
      mem_wdata_d = bus.host_wdata;
    end else if (mc_gnt) begin
      mem_addr_d  = bus.mc_addr;
      mem_wdata_d = bus.mc_wdata;
    end
    rd_v1_d  = (host_gnt & ~bus.host_we) | (mc_gnt & ~bus.mc_we);
    rd_mc1_d = mc_gnt;
    rd_v2_d  = rd_v1_q;
    rd_mc2_d = rd_mc1_q;

    host_rvalid  = rd_v2_q & ~rd_mc2_q;
    mc_rvalid    = rd_v2_q & rd_mc2_q;
    host_rdata_d = host_rvalid ? bus.mem_rdata : host_rdata_q;
    mc_rdata_d   = mc_rvalid ? bus.mem_rdata : mc_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB;
      starve_q     <= '0;
`ifdef REGFILE_ARB_LOCK_EN
      lock_cnt_q   <= '0;
      host_prio_q  <= 1'b0;
`endif
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_v1_q      <= 1'b0;
      rd_mc1_q     <= 1'b0;
      rd_v2_q      <= 1'b0;
      rd_mc2_q     <= 1'b0;
      host_rdata_q <= '0;
      mc_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
`ifdef REGFILE_ARB_LOCK_EN
      lock_cnt_q   <= lock_cnt_d;
      host_prio_q  <= host_prio_d;
`endif
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_v1_q      <= rd_v1_d;
      rd_mc1_q     <= rd_mc1_d;
      rd_v2_q      <= rd_v2_d;
      rd_mc2_q     <= rd_mc2_d;
      host_rdata_q <= host_rdata_d;
      mc_rdata_q   <= mc_rdata_d;
    end
  end

  assign bus.host_gnt    = host_gnt;
  assign bus.mc_gnt      = mc_gnt;
  assign bus.lock_err    = lock_err;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.host_rvalid = host_rvalid;
  assign bus.host_rdata  = host_rdata_d;
  assign bus.mc_rvalid   = mc_rvalid;
  assign bus.mc_rdata    = mc_rdata_d;
endmodule

// File: tb/tb_regfile_arb.sv
// Self-checking bench for regfile_arb: directed scenarios plus random traffic, a reference
// arbitration/memory model and a read-return scoreboard. Honours REGFILE_ARB_LOCK_EN.
module tb_regfile_arb;
  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 8;
  localparam int STARVE_LIMIT = 4;
  localparam int LOCK_MAX     = 8;
`ifdef REGFILE_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] init_val(input int unsigned a);
    case (a)
      5:       return 8'hA7;
      16:      return 8'h11;
      32:      return 8'h22;
      default: return 8'(a * 73 + 19);
    endcase
  endfunction

  // Synchronous RAM attached to the DUT's memory port.
  logic [7:0] ram [128];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  typedef struct { logic [7:0] d; int unsigned c; } rd_t;
  rd_t         hq[$];
  rd_t         mq[$];
  logic [7:0]  ref_mem [128];
  bit          ref_ready = 1'b0;
  int unsigned cyc = 0;
  bit          m_locked, m_prio;
  int unsigned m_sc, m_lc;
  bit          pv_en, pv_we;
  logic [6:0]  pv_addr;
  logic [7:0]  pv_wdata;
  logic [6:0]  wlog[$];
  byte         glog[$];
  bit          log_on = 1'b0;
  int unsigned err_seen = 0;

  // Reference model: predicts grants/lock_err from the arbitration rules and issues
  // expected reads into the scoreboard queues using a reference copy of the register file.
  always @(negedge clk) begin : model
    bit eh, em, ee;
    cyc++;
    if (!ref_ready) begin
      for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
      ref_ready = 1'b1;
    end
    if (!reset) begin
      m_locked = 1'b0; m_prio = 1'b0; m_sc = 0; m_lc = 0; pv_en = 1'b0;
      hq.delete();
      mq.delete();
    end else begin
      chk("mem_en", bus.mem_en, pv_en);
      if (pv_en) begin
        chk("mem_we", bus.mem_we, pv_we);
        chk("mem_addr", bus.mem_addr, pv_addr);
        if (pv_we) chk("mem_wdata", bus.mem_wdata, pv_wdata);
      end
      if (bus.mem_en && bus.mem_we) wlog.push_back(bus.mem_addr);

      eh = 1'b0; em = 1'b0; ee = 1'b0;
      if (!m_locked) begin
        if (bus.host_req && bus.mc_req) begin
          if (m_prio || m_sc < STARVE_LIMIT) eh = 1'b1;
          else                               em = 1'b1;
          m_prio = 1'b0;
        end else begin
          eh = bus.host_req;
          em = bus.mc_req;
        end
        if (LOCK_EN && em && bus.mc_lock) begin m_locked = 1'b1; m_lc = 0; end
      end else begin
        em = bus.mc_req;
        m_lc++;
        if (!bus.mc_lock) m_locked = 1'b0;
        else if (m_lc == LOCK_MAX) begin m_locked = 1'b0; ee = 1'b1; m_prio = 1'b1; end
      end
      if (!bus.mc_req || em || ee) m_sc = 0;
      else if (eh)                 m_sc++;

      chk("host_gnt", bus.host_gnt, eh);
      chk("mc_gnt", bus.mc_gnt, em);
      chk("lock_err", bus.lock_err, ee);
      if (bus.lock_err) err_seen++;
      if (log_on) glog.push_back(bus.host_gnt ? 8'h48 : (bus.mc_gnt ? 8'h4D : 8'h2D));

      pv_en = eh | em;
      if (eh) begin
        pv_we = bus.host_we; pv_addr = bus.host_addr; pv_wdata = bus.host_wdata;
        if (bus.host_we) ref_mem[bus.host_addr] = bus.host_wdata;
        else             hq.push_back('{ref_mem[bus.host_addr], cyc + 2});
      end else if (em) begin
        pv_we = bus.mc_we; pv_addr = bus.mc_addr; pv_wdata = bus.mc_wdata;
        if (bus.mc_we) ref_mem[bus.mc_addr] = bus.mc_wdata;
        else           mq.push_back('{ref_mem[bus.mc_addr], cyc + 2});
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  int unsigned mcyc = 0;
  logic [7:0]  h_last = '0;
  logic [7:0]  m_last = '0;
  always @(negedge clk) begin : monitor
    rd_t e;
    mcyc++;
    if (!reset) begin
      h_last = '0; m_last = '0;
    end else begin
      if (bus.host_rvalid) begin
        if (hq.size() == 0) chk("host_rvalid_unexpected", bus.host_rvalid, 0);
        else begin
          e = hq.pop_front();
          chk("host_rdata", bus.host_rdata, e.d);
          chk("host_rlatency", mcyc, e.c);
          h_last = e.d;
        end
      end else chk("host_rdata_hold", bus.host_rdata, h_last);
      if (bus.mc_rvalid) begin
        if (mq.size() == 0) chk("mc_rvalid_unexpected", bus.mc_rvalid, 0);
        else begin
          e = mq.pop_front();
          chk("mc_rdata", bus.mc_rdata, e.d);
          chk("mc_rlatency", mcyc, e.c);
          m_last = e.d;
        end
      end else chk("mc_rdata_hold", bus.mc_rdata, m_last);
    end
  end

  // Drivers: called just after a rising edge; hold the request until it is granted.
  task automatic host_xfer(input bit we, input logic [6:0] a, input logic [7:0] d);
    int unsigned w = 0;
    bus.host_we = we; bus.host_addr = a; bus.host_wdata = d; bus.host_req = 1'b1;
    @(negedge clk);
    while (!bus.host_gnt && w < 100) begin w++; @(negedge clk); end
    if (!bus.host_gnt) chk("host_gnt_timeout", bus.host_gnt, 1);
    @(posedge clk); #1;
    bus.host_req = 1'b0;
  endtask

  task automatic mc_xfer(input bit we, input logic [6:0] a, input logic [7:0] d, input bit lk);
    int unsigned w = 0;
    bus.mc_we = we; bus.mc_addr = a; bus.mc_wdata = d; bus.mc_lock = lk; bus.mc_req = 1'b1;
    @(negedge clk);
    while (!bus.mc_gnt && w < 100) begin w++; @(negedge clk); end
    if (!bus.mc_gnt) chk("mc_gnt_timeout", bus.mc_gnt, 1);
    @(posedge clk); #1;
    bus.mc_req = 1'b0; bus.mc_lock = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs();
    chk("rst_host_gnt", bus.host_gnt, 0);
    chk("rst_mc_gnt", bus.mc_gnt, 0);
    chk("rst_host_rvalid", bus.host_rvalid, 0);
    chk("rst_mc_rvalid", bus.mc_rvalid, 0);
    chk("rst_host_rdata", bus.host_rdata, 0);
    chk("rst_mc_rdata", bus.mc_rdata, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_lock_err", bus.lock_err, 0);
  endtask

  bit mc_done;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    string pat;
    int    idx;
    reset = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 7'h05; bus.host_wdata = '0;
    bus.mc_req = 1'b1; bus.mc_we = 1'b0; bus.mc_lock = 1'b1; bus.mc_addr = 7'h10; bus.mc_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    bus.host_req = 1'b0; bus.mc_req = 1'b0; bus.mc_lock = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    idle(2);

    // Host-only read of 0x05 (holds 0xA7).
    host_xfer(1'b0, 7'h05, 8'h00);
    idle(4);

    // Both requesting continuously: H,H,H,H,M repeating.
    glog.delete();
    log_on = 1'b1;
    fork
      for (int i = 0; i < 16; i++) host_xfer(1'b0, 7'($urandom_range(64, 127)), 8'h00);
      for (int i = 0; i < 4; i++)  mc_xfer(1'b0, 7'($urandom_range(64, 127)), 8'h00, 1'b0);
    join
    log_on = 1'b0;
    pat = "HHHHMHHHHM";
    for (int i = 0; i < 10; i++)
      chk("grant_seq", (i < glog.size()) ? glog[i] : 8'h3F, pat[i]);
    idle(3);

    // Locked write burst 0x41..0x43 under host pressure.
    wlog.delete();
    fork
      for (int i = 0; i < 6; i++) host_xfer(1'b1, 7'(7'h60 + i), 8'($urandom));
      begin
        mc_xfer(1'b1, 7'h41, 8'hC1, 1'b1);
        mc_xfer(1'b1, 7'h42, 8'hC2, 1'b1);
        mc_xfer(1'b1, 7'h43, 8'hC3, 1'b0);
      end
    join
    idle(3);
`ifdef REGFILE_ARB_LOCK_EN
    idx = -1;
    foreach (wlog[i]) if (idx < 0 && wlog[i] == 7'h41) idx = i;
    chk("lock_wr_first", (idx >= 0 && idx + 2 < wlog.size()) ? 32'(wlog[idx]) : 32'hFFFF, 7'h41);
    chk("lock_wr_second", (idx >= 0 && idx + 2 < wlog.size()) ? 32'(wlog[idx+1]) : 32'hFFFF, 7'h42);
    chk("lock_wr_third", (idx >= 0 && idx + 2 < wlog.size()) ? 32'(wlog[idx+2]) : 32'hFFFF, 7'h43);
`endif

    // mc_lock held for ~20 cycles with the host contending: forced release.
    err_seen = 0;
    mc_done  = 1'b0;
    fork
      while (!mc_done) host_xfer(1'b0, 7'($urandom_range(48, 55)), 8'h00);
      begin
        int unsigned start;
        start = cyc;
        while (cyc - start < 20) mc_xfer(1'b0, 7'($urandom_range(56, 63)), 8'h00, 1'b1);
        mc_done = 1'b1;
      end
    join
    chk("lock_err_seen", (err_seen != 0) ? 32'd1 : 32'd0, 32'(LOCK_EN));
    idle(4);

    // Interleaved reads: M(0x10)=0x11 then H(0x20)=0x22.
    mc_xfer(1'b0, 7'h10, 8'h00, 1'b0);
    host_xfer(1'b0, 7'h20, 8'h00);
    idle(4);

    // Reset with two reads in flight.
    host_xfer(1'b0, 7'h05, 8'h00);
    mc_xfer(1'b0, 7'h10, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #3;
    reset = 1'b1;
    idle(6);

    // Random traffic from both requesters.
    fork
      for (int i = 0; i < 400; i++) begin
        idle($urandom_range(0, 2));
        host_xfer(1'($urandom), 7'($urandom), 8'($urandom));
      end
      for (int i = 0; i < 400; i++) begin
        idle($urandom_range(0, 2));
        mc_xfer(1'($urandom), 7'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      end
    join
    idle(6);
    chk("host_queue_drained", hq.size(), 0);
    chk("mc_queue_drained", mq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
